// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the existing receiver:
// FSM state encoding, data width, default bit period and counter sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 4166;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each bit with bit_end. Shared with the receiver for its sample tick.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one-entry holding register feeding an 8N1 framer, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_valid_in,
  output logic                 tx_ready_out,
  output logic                 tx_busy_out,
  output logic                 tx_done_out,
  output logic                 tx_line_uart
);

  localparam int IDX_W = clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic accept;
  logic unload;
  logic bit_end;
  logic baud_clr;

  assign accept       = tx_valid_in && !hold_full_q;
  assign tx_ready_out = !hold_full_q;
  assign tx_busy_out  = busy_q;
  assign tx_done_out  = done_q;
  assign tx_line_uart = line_q;

  // Counter idles at zero and restarts whenever the FSM changes state.
  assign baud_clr = (state_q == IDLE) || (state_d != state_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk_in),
    .rst    (rst),
    .clr    (baud_clr),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    unload     = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_q != IDLE);
    line_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          unload  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        line_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        line_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
`endif
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_d = parity_q;
        if (bit_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
`endif
      STOP: begin
        line_d = 1'b1;
        if (bit_end) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            // A queued byte starts immediately, keeping frames gap-free.
            if (hold_full_q) begin
              unload  = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (unload) begin
      shift_d  = hold_data_q;
`ifdef UART_TX_PARITY_EN
      parity_d = ^hold_data_q;
`endif
    end
  end

  always_comb begin
    hold_full_d = accept || (hold_full_q && !unload);
    hold_data_d = accept ? tx_data_in : hold_data_q;
  end

  // Line, busy and done are registered from the current state, so they
  // trail the FSM by one clock and stay aligned with each other.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      line_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      line_q      <= line_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk_in) begin
    hold_data_q <= hold_data_d;
    shift_q     <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q    <= parity_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a frame-schedule model predicts
// every output each cycle; directed frames pin the model with literal bit patterns.
module tb_uart_tx_serializer;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR    = 1;
  localparam int STOP_B = 2;
  localparam logic [11:0] EXP45 = 12'b1110_1000_1010;
`else
  localparam int PAR    = 0;
  localparam int STOP_B = 1;
  localparam logic [11:0] EXP45 = 12'b0010_1000_1010;
`endif
  localparam int NB = 1 + 8 + PAR + STOP_B;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready_out;
  logic       tx_busy_out;
  logic       tx_done_out;
  logic       tx_line_uart;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  uart_tx_serializer #(
    .CLKS_PER_BIT(C),
    .STOP_BITS   (STOP_B)
  ) dut (
    .clk_in      (clk),
    .rst         (rst),
    .tx_data_in  (tx_data),
    .tx_valid_in (tx_valid),
    .tx_ready_out(tx_ready_out),
    .tx_busy_out (tx_busy_out),
    .tx_done_out (tx_done_out),
    .tx_line_uart(tx_line_uart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Frame model: each accepted byte becomes a scheduled frame on the line.
  longint     cyc       = 0;
  longint     cur_start = -1000000;
  longint     free_edge = 0;
  logic       hold_full_m = 1'b0;
  logic       old_full;
  logic [7:0] hold_byte_m = 8'h00;
  logic [7:0] cur_byte    = 8'h00;
  logic       exp_line = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      hold_full_m = 1'b0;
      cur_start   = -1000000;
      free_edge   = 0;
      exp_line = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      if (cyc >= cur_start && cyc < cur_start + NB * C) begin
        exp_line = frame_bit(cur_byte, int'((cyc - cur_start) / C));
        exp_busy = 1'b1;
        exp_done = (cyc == cur_start + NB * C - 1);
      end else begin
        exp_line = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      end
      old_full = hold_full_m;
      if (old_full && cyc >= free_edge) begin
        cur_start   = cyc + 1;
        cur_byte    = hold_byte_m;
        free_edge   = cyc + NB * C;
        hold_full_m = 1'b0;
      end
      if (tx_valid && !old_full) begin
        hold_full_m = 1'b1;
        hold_byte_m = tx_data;
      end
    end
    exp_ready = !hold_full_m;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("line",  tx_line_uart, exp_line);
      check("ready", tx_ready_out, exp_ready);
      check("busy",  tx_busy_out,  exp_busy);
      check("done",  tx_done_out,  exp_done);
    end
  end

  // Offer a byte until accepted; returns 1 time unit after the accepting edge.
  task automatic offer(input logic [7:0] b, input bit keep_valid, output bit ok);
    bit r;
    ok = 1'b0;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 500; i++) begin
      r = tx_ready_out;
      @(posedge clk);
      #1;
      if (r) begin ok = 1'b1; break; end
    end
    if (!keep_valid) tx_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_capture(input logic [7:0] b, input logic [11:0] expb, input string nm);
    bit ok;
    int lat, errs, dones, done_at;
    offer(b, 1'b0, ok);
    lat = 0;
    while (tx_line_uart && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 2);
    errs = 0; dones = 0; done_at = -1;
    for (int k = 0; k < NB * C; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (tx_line_uart !== expb[k / C]) errs++;
      if (tx_done_out) begin dones++; done_at = k; end
    end
    @(posedge clk); #1;
    if (tx_done_out) dones++;
    check({nm, "_bits"}, errs, 0);
    check({nm, "_done_count"}, dones, 1);
    check({nm, "_done_pos"}, done_at, NB * C - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, seen;
    int cnt, dens;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_line",  tx_line_uart, 1);
    check("rst_ready", tx_ready_out, 1);
    check("rst_busy",  tx_busy_out,  0);
    check("rst_done",  tx_done_out,  0);
    chk_en = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx_line_uart) cnt++;
    end
    check("idle_high_cycles", cnt, 100);

    send_capture(8'h45, EXP45, "byte45");
    repeat (5) @(posedge clk);
    #1;

    // Back-to-back with valid held high.
    offer(8'h05, 1'b1, ok);
    offer(8'h03, 1'b1, ok);
    check("b2b_accept_while_busy", tx_busy_out, 1);
    check("b2b_ready_low", tx_ready_out, 0);
    // Third byte offered into a full holding register with changing data.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'($urandom);
      @(posedge clk); #1;
      if (!tx_ready_out) cnt++;
    end
    check("backpressure_ready_low", cnt, 8);
    tx_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx_done_out) begin seen = 1'b1; break; end
    end
    check("b2b_done_seen", seen, 1);
    check("b2b_ready_after_unload", tx_ready_out, 1);
    @(posedge clk); #1;
    check("b2b_no_gap", tx_line_uart, 0);
    repeat (NB * C + 10) @(posedge clk);
    #1;

    // Reset during data bit 3 of 0xA5 with another byte queued.
    offer(8'hA5, 1'b0, ok);
    offer(8'h3C, 1'b0, ok);
    check("midrst_frame_started", tx_line_uart, 0);
    repeat (16) @(posedge clk);
    #1;
    check("midrst_bit3_value", tx_line_uart, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_line", tx_line_uart, 1);
    check("midrst_busy", tx_busy_out, 0);
    check("midrst_ready", tx_ready_out, 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx_done_out || !tx_line_uart || tx_busy_out) cnt++;
    end
    check("midrst_quiet_after", cnt, 0);

`ifdef UART_TX_PARITY_EN
    send_capture(8'h07, 12'b1110_0000_1110, "par07");
    send_capture(8'h03, 12'b1100_0000_0110, "par03");
    repeat (5) @(posedge clk);
    #1;
`endif

    // Randomized traffic with varying offer density and one reset.
    dens = 2;
    for (int i = 0; i < 2500; i++) begin
      if (i % 250 == 0) dens = $urandom_range(1, 4);
      tx_valid = ($urandom_range(0, 3) < dens);
      tx_data  = 8'($urandom);
      rst      = (i == 1333);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    rst = 1'b0;
    repeat (NB * C * 2 + 20) @(posedge clk);
    #1;
    check("drain_idle_line", tx_line_uart, 1);
    check("drain_idle_ready", tx_ready_out, 1);

    chk_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit half of the processor's UART peripheral; drives tx_line_uart at the top level of single_cycle_p2.
- Accepts bytes from the memory-mapped UART register logic through a valid/ready handshake and frames each as 8N1 (optionally 8E1), LSB first.
- Has a one-entry holding register, so the core can queue the next byte while the current frame shifts out.
- Back-to-back frames are sent with no idle gap.

Parameters:
- CLKS_PER_BIT, 4166: clock cycles per UART bit (8333 ns bit at 2 ns clock); legal range ≥2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data_in  input  8  byte to transmit.
- tx_valid_in  input  1  producer offers tx_data_in.
- tx_ready_out  output  1  holding register empty; a byte is accepted at an edge where valid and ready are both high.
- tx_busy_out  output  1  high while any frame bit (start through last stop) is on the line.
- tx_done_out  output  1  one-cycle pulse at the final clock of the last stop bit.
- tx_line_uart  output  1  serial line; idles high; registered output.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst is synchronous and active-high.
- Reset values: tx_line_uart=1, tx_ready_out=1, tx_busy_out=0, tx_done_out=0. Holding register empty, baud counter 0, FSM in IDLE.
- Reset mid-frame aborts the frame. The line is high at the edge after rst is sampled high, and the queued byte is discarded.
- Handshake: an accept loads the holding register and drops tx_ready_out at the next edge. tx_data_in is ignored when not accepted.
- FSM states: IDLE, START, DATA, PARITY (only when the feature is compiled in), STOP.
- IDLE: if the holding register is full, move it into the shift register, empty the holding register, and go to START. tx_ready_out rises at the same edge.
- An accept at edge k while in IDLE with the holding register empty drives the line low at edge k+2 (one edge to load, one edge to start).
- Each state holds the line for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state change.
- START: line=0.
- DATA: line = shift register bit 0. The register shifts right at each bit boundary; a bit index counts 0..7, then the FSM moves on.
- STOP: line=1 for STOP_BITS×CLKS_PER_BIT cycles.
- At the last cycle of STOP, tx_done_out is pulsed. If the holding register is full, the FSM goes directly to START (no idle cycle); otherwise it goes to IDLE.
- tx_busy_out is high in START, DATA, PARITY and STOP.
- Simultaneous accept and unload in the same cycle: both occur. The new byte lands in the now-empty holding register.
- tx_data_in is captured only at accept; later changes have no effect.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length is 11 bits (1 stop).
- Undefined: no PARITY state, no parity logic. Frame length is 10 bits.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - default CLKS_PER_BIT;
  - a counter-width function clog2(CLKS_PER_BIT).
- The package is shared with the existing receiver.
- One sub-module, uart_baud_tick: counter with clear input, produces a 1-cycle bit_end pulse when the count reaches CLKS_PER_BIT-1. It is reusable by the receiver for its sample tick.

Test Plan:
- Reset: hold rst 3 cycles, then release → tx_line_uart=1, tx_ready_out=1, tx_busy_out=0, tx_done_out=0, and the line stays high for 100 cycles with no valid.
- Single byte, CLKS_PER_BIT=4:
  - send 0x45 → line 0,1,0,1,0,0,0,1,0,1, each held for exactly 4 cycles;
  - first low at accept+2 edges;
  - tx_done_out pulses once, on the last stop cycle.
- Back-to-back, CLKS_PER_BIT=4:
  - offer 0x05 then 0x03 with valid held high;
  - the second byte is accepted while the first is shifting;
  - the start bit of 0x03 immediately follows the stop bit of 0x05, with no idle cycle;
  - tx_ready_out stays low until the second byte is unloaded.
- Backpressure: holding register full and a third byte offered → tx_ready_out=0, the byte is not accepted, and data changes are ignored until ready rises.
- Reset mid-frame: assert rst during data bit 3 of 0xA5 → line high at the next edge, tx_busy_out=0, the queued byte is dropped, and no tx_done_out pulse occurs.
- Parity, with UART_TX_PARITY_EN and STOP_BITS=2:
  - send 0x07 → parity bit 1, then two stop bits (8 cycles high at CLKS_PER_BIT=4);
  - send 0x03 → parity bit 0.
